// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg                                                             |
// | Shared constants and pipeline-register types for the RV32I core.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package core_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   // Contents of a fetch->decode style pipeline register; also reusable by DE/EX
   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcplus4;
      logic            valid;
   } if_de_t;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_reg                                                               |
// | Fetch program counter: redirect beats stall, otherwise advance by 4. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pc_reg #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_target,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4
);
   import core_pkg::*;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_plus4;
   logic            w_unused_target_lsbs;

   // Sequential successor wraps naturally at 2^XLEN
   assign w_pc_plus4 = r_pc + XLEN'(4);

   // Target is forced word-aligned, so its low bits are intentionally dropped
   assign w_unused_target_lsbs = ^i_target[1:0];

   // PC update: reset, then redirect (even while stalled), then hold, then +4
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (i_redirect) begin
         r_pc <= {i_target[XLEN-1:2], 2'b00};
      end else if (!i_stall) begin
         r_pc <= w_pc_plus4;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/fetch_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_decode_stage                                                   |
// | Fetch PC, instruction-memory address and the IF/DE pipeline register.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fetch_decode_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_f,
   input  logic            stall_d,
   input  logic            flush_d,
   input  logic            PCSrc_e,
   input  logic [XLEN-1:0] PCTarget_e,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     Instr_de,
   output logic [24:0]     VecImm_de,
   output logic [XLEN-1:0] PC_de,
   output logic [XLEN-1:0] PCPlus4_de,
   output logic            valid_de
);
   import core_pkg::*;

   // The pipeline-register struct is sized by the package datapath width
   if (XLEN != core_pkg::XLEN) begin : g_xlen_check
      $error("fetch_decode_stage: XLEN must match core_pkg::XLEN");
   end

   localparam if_de_t c_bubble = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};

   logic [XLEN-1:0] w_pc_f;
   logic [XLEN-1:0] w_pc_plus4_f;
   if_de_t          r_if_de;

   pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_stall    (stall_f),
      .i_redirect (PCSrc_e),
      .i_target   (PCTarget_e),
      .o_pc       (w_pc_f),
      .o_pc_plus4 (w_pc_plus4_f)
   );

   // IF/DE register: reset/flush load a bubble, stall holds, else capture fetch
   always_ff @(posedge clk) begin
      if (!rst_n || flush_d) begin
         r_if_de <= c_bubble;
      end else if (!stall_d) begin
         r_if_de <= '{instr: imem_rdata, pc: w_pc_f, pcplus4: w_pc_plus4_f, valid: 1'b1};
      end
   end

   assign imem_addr  = w_pc_f;
   assign Instr_de   = r_if_de.instr;
   assign VecImm_de  = r_if_de.instr[31:7];
   assign PC_de      = r_if_de.pc;
   assign PCPlus4_de = r_if_de.pcplus4;
   assign valid_de   = r_if_de.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_decode_stage                                                |
// | Directed self-checking bench for fetch_decode_stage.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fetch_decode_stage;

   localparam logic [31:0] c_nop  = 32'h0000_0013;
   localparam logic [31:0] c_salt = 32'h5A5A_0000;

   logic        clk;
   logic        rst_n;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        PCSrc_e;
   logic [31:0] PCTarget_e;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] Instr_de;
   logic [24:0] VecImm_de;
   logic [31:0] PC_de;
   logic [31:0] PCPlus4_de;
   logic        valid_de;

   logic        ovr_en;
   logic [31:0] ovr_word;

   int n_asserts = 0;
   int n_fail    = 0;

   fetch_decode_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .flush_d    (flush_d),
      .PCSrc_e    (PCSrc_e),
      .PCTarget_e (PCTarget_e),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .Instr_de   (Instr_de),
      .VecImm_de  (VecImm_de),
      .PC_de      (PC_de),
      .PCPlus4_de (PCPlus4_de),
      .valid_de   (valid_de)
   );

   // Instruction memory: word derived from the address unless overridden
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ c_salt;
   endfunction

   assign imem_rdata = ovr_en ? ovr_word : mem(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifde(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic v);
      chk({tag, ".instr"},  Instr_de,           instr);
      chk({tag, ".vecimm"}, {7'd0, VecImm_de},  {7'd0, instr[31:7]});
      chk({tag, ".pc"},     PC_de,              pc);
      chk({tag, ".pc4"},    PCPlus4_de,         pc4);
      chk({tag, ".valid"},  {31'd0, valid_de},  {31'd0, v});
   endtask

   initial begin
      rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
      PCSrc_e = 1'b0; PCTarget_e = '0; ovr_en = 1'b0; ovr_word = '0;

      // Reset state
      step(); step();
      chk("rst.pc_f", imem_addr, 32'h0);
      chk_ifde("rst", c_nop, 32'h0, 32'h0, 1'b0);

      // 1: free-run, decode lags fetch by one cycle
      rst_n = 1'b1;
      step();
      chk("run1.pc_f", imem_addr, 32'h4);
      chk_ifde("run1", mem(32'h0), 32'h0, 32'h4, 1'b1);
      step();
      chk("run2.pc_f", imem_addr, 32'h8);
      chk_ifde("run2", mem(32'h4), 32'h4, 32'h8, 1'b1);
      step();
      chk("run3.pc_f", imem_addr, 32'hC);
      chk_ifde("run3", mem(32'h8), 32'h8, 32'hC, 1'b1);

      // 2: immediate field slice of addi x1,x0,-1
      ovr_en = 1'b1; ovr_word = 32'hFFF0_0093;
      step();
      ovr_en = 1'b0;
      chk("imm.instr",  Instr_de, 32'hFFF0_0093);
      chk("imm.vecimm", {7'd0, VecImm_de}, 32'h01FF_E001);
      chk("imm.pc_f",   imem_addr, 32'h10);

      // 3: taken branch with flush at PC_f=0x10, misaligned target
      PCSrc_e = 1'b1; PCTarget_e = 32'h0000_0102; flush_d = 1'b1;
      step();
      PCSrc_e = 1'b0; flush_d = 1'b0;
      chk("br.pc_f", imem_addr, 32'h100);
      chk_ifde("br.bubble", c_nop, 32'h0, 32'h0, 1'b0);
      step();
      chk("br.pc_f2", imem_addr, 32'h104);
      chk_ifde("br.tgt", mem(32'h100), 32'h100, 32'h104, 1'b1);

      // 4: get to PC_f=0x20 with a real instruction in decode, then stall both
      PCSrc_e = 1'b1; PCTarget_e = 32'h1C; flush_d = 1'b1;
      step();
      PCSrc_e = 1'b0; flush_d = 1'b0;
      step();
      chk("st.pre_pc_f", imem_addr, 32'h20);
      stall_f = 1'b1; stall_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st.pc_f", imem_addr, 32'h20);
         chk_ifde("st.hold", mem(32'h1C), 32'h1C, 32'h20, 1'b1);
      end
      stall_f = 1'b0; stall_d = 1'b0;
      step();
      chk("st.rel_pc_f", imem_addr, 32'h24);
      chk_ifde("st.rel", mem(32'h20), 32'h20, 32'h24, 1'b1);

      // 5a: flush beats stall_d
      stall_d = 1'b1; flush_d = 1'b1;
      step();
      stall_d = 1'b0; flush_d = 1'b0;
      chk("fl.pc_f", imem_addr, 32'h28);
      chk_ifde("fl.bubble", c_nop, 32'h0, 32'h0, 1'b0);
      // 5b: redirect beats stall_f
      stall_f = 1'b1; PCSrc_e = 1'b1; PCTarget_e = 32'h40;
      step();
      stall_f = 1'b0; PCSrc_e = 1'b0;
      chk("rd.pc_f", imem_addr, 32'h40);
      chk_ifde("rd", mem(32'h28), 32'h28, 32'h2C, 1'b1);

      // 6a: PC wraps at the top of the address space
      PCSrc_e = 1'b1; PCTarget_e = 32'hFFFF_FFFC; flush_d = 1'b1;
      step();
      PCSrc_e = 1'b0; flush_d = 1'b0;
      chk("wr.pc_top", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wr.pc_f", imem_addr, 32'h0);
      chk_ifde("wr", mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1);
      step();
      chk("wr.pc_f2", imem_addr, 32'h4);

      // 6b: reset during stall with a pending redirect discards everything
      stall_f = 1'b1; stall_d = 1'b1; PCSrc_e = 1'b1; PCTarget_e = 32'h80; rst_n = 1'b0;
      step();
      chk("mrst.pc_f", imem_addr, 32'h0);
      chk_ifde("mrst", c_nop, 32'h0, 32'h0, 1'b0);
      stall_f = 1'b0; stall_d = 1'b0; PCSrc_e = 1'b0; rst_n = 1'b1;
      step();
      chk("mrst.pc_f2", imem_addr, 32'h4);
      chk_ifde("mrst.run", mem(32'h0), 32'h0, 32'h4, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
